fsm_coverage_monitor: RTL and testbench

FSM_COVERAGE_MONITOR -- requirements
Module: fsm_coverage_monitor

---
 rtl/fsm_coverage_monitor_pkg.sv | 16 +
 rtl/fsm_coverage_monitor_if.sv | 36 +++
 rtl/fsm_coverage_monitor_sat_counter.sv | 20 ++
 rtl/fsm_coverage_monitor.sv | 104 ++++++++++
 tb/tb_fsm_coverage_monitor.sv | 140 ++++++++++++++
 5 files changed

// File: rtl/fsm_coverage_monitor_pkg.sv
// FSM coverage monitor: shared monitor states and default widths.
// Imported by the interface, the counter and the top.
package fsm_mon_pkg;

  typedef enum logic [1:0] {
    MON_IDLE  = 2'd0,
    MON_TRACK = 2'd1,
    MON_FAULT = 2'd2
  } mon_state_t;

  localparam int DEF_STATE_W     = 2;
  localparam int DEF_NUM_STATES  = 4;
  localparam int DEF_CNT_W       = 8;
  localparam int DEF_STUCK_LIMIT = 16;

endpackage

// File: rtl/fsm_coverage_monitor_if.sv
// FSM coverage monitor bus: observed-FSM samples in, coverage results out.
// The master drives samples, the slave (monitor) drives results.
interface fsm_coverage_monitor_if
  import fsm_mon_pkg::*;
#(
  parameter int STATE_W    = DEF_STATE_W,
  parameter int NUM_STATES = DEF_NUM_STATES,
  parameter int CNT_W      = DEF_CNT_W
) ();

  logic                             clear;
  logic                             state_valid;
  logic [STATE_W-1:0]               state_in;
  logic [NUM_STATES*NUM_STATES-1:0] legal_mask;

  logic [NUM_STATES-1:0]            visited;
  logic                             all_visited;
  logic                             illegal_flag;
  logic [STATE_W-1:0]               illegal_from;
  logic [STATE_W-1:0]               illegal_to;
  logic [CNT_W-1:0]                 trans_count;
  logic                             stuck_flag;

  modport master (
    output clear, state_valid, state_in, legal_mask,
    input  visited, all_visited, illegal_flag,
    input  illegal_from, illegal_to, trans_count, stuck_flag
  );

  modport slave (
    input  clear, state_valid, state_in, legal_mask,
    output visited, all_visited, illegal_flag,
    output illegal_from, illegal_to, trans_count, stuck_flag
  );

endinterface

// File: rtl/fsm_coverage_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear.
// clr together with en restarts the count at one instead of zero.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= en ? W'(1) : '0;
    end else if (en && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/fsm_coverage_monitor.sv
// FSM coverage monitor: records visited states, legal transition count,
// the first illegal transition and a sticky stuck-state flag.
module fsm_coverage_monitor
  import fsm_mon_pkg::*;
#(
  parameter int STATE_W     = DEF_STATE_W,
  parameter int NUM_STATES  = DEF_NUM_STATES,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int STUCK_LIMIT = DEF_STUCK_LIMIT
) (
  input logic clk,
  input logic rst,
  fsm_coverage_monitor_if.slave mon
);

  localparam int SW = $clog2(STUCK_LIMIT + 1);

  mon_state_t            st;
  logic [STATE_W-1:0]    prev_state;
  logic [NUM_STATES-1:0] visited;
  logic                  all_visited;
  logic                  illegal_flag;
  logic [STATE_W-1:0]    illegal_from;
  logic [STATE_W-1:0]    illegal_to;
  logic                  stuck_flag;
  logic [CNT_W-1:0]      trans_count;
  logic [SW-1:0]         stuck_cnt;

  logic                  wipe;
  logic                  smp;
  logic                  tracking;
  logic                  same;
  logic                  change;
  logic                  legal;
  logic                  stuck_hit;
  logic [NUM_STATES-1:0] hit;

  assign wipe     = rst | mon.clear;
  assign smp      = mon.state_valid & ~wipe;
  assign tracking = (st != MON_IDLE);
  assign same     = tracking && (mon.state_in == prev_state);
  assign change   = tracking && (mon.state_in != prev_state);
  assign legal    = mon.legal_mask[{prev_state, mon.state_in}];
  assign hit      = NUM_STATES'(1) << mon.state_in;

  // The sample that takes the run length to STUCK_LIMIT raises the flag.
  assign stuck_hit = same ? (stuck_cnt == SW'(STUCK_LIMIT - 1))
                          : (STUCK_LIMIT == 1);

  sat_counter #(.W(CNT_W)) u_trans (
    .clk (clk),
    .clr (wipe),
    .en  (smp & change & legal),
    .q   (trans_count)
  );

  // First sample or a state change restarts the run length at one.
  sat_counter #(.W(SW)) u_stuck (
    .clk (clk),
    .clr (wipe | (smp & ~same)),
    .en  (smp),
    .q   (stuck_cnt)
  );

  always_ff @(posedge clk) begin
    if (wipe) begin
      st           <= MON_IDLE;
      prev_state   <= '0;
      visited      <= '0;
      all_visited  <= 1'b0;
      illegal_flag <= 1'b0;
      illegal_from <= '0;
      illegal_to   <= '0;
      stuck_flag   <= 1'b0;
    end else if (mon.state_valid) begin
      prev_state  <= mon.state_in;
      visited     <= visited | hit;
      all_visited <= &(visited | hit);
      if (stuck_hit) stuck_flag <= 1'b1;
      case (st)
        MON_IDLE: st <= MON_TRACK;
        MON_TRACK: begin
          if (change && !legal) begin
            illegal_flag <= 1'b1;
            illegal_from <= prev_state;
            illegal_to   <= mon.state_in;
            st           <= MON_FAULT;
          end
        end
        MON_FAULT: st <= MON_FAULT;
        default:   st <= MON_IDLE;
      endcase
    end
  end

  assign mon.visited      = visited;
  assign mon.all_visited  = all_visited;
  assign mon.illegal_flag = illegal_flag;
  assign mon.illegal_from = illegal_from;
  assign mon.illegal_to   = illegal_to;
  assign mon.trans_count  = trans_count;
  assign mon.stuck_flag   = stuck_flag;

endmodule

// File: tb/tb_fsm_coverage_monitor.sv
// Directed scoreboard bench for fsm_coverage_monitor.
// A second instance with CNT_W=2 shares the stimulus to show saturation.
module tb_fsm_coverage_monitor;
  import fsm_mon_pkg::*;

  typedef struct {
    logic [3:0] vis;
    logic       av;
    logic       ill;
    logic [1:0] f;
    logic [1:0] t;
    logic [7:0] tc;
    logic       stk;
    mon_state_t st;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  fsm_coverage_monitor_if #(.STATE_W(2), .NUM_STATES(4), .CNT_W(8)) bus ();
  fsm_coverage_monitor_if #(.STATE_W(2), .NUM_STATES(4), .CNT_W(2)) bus2 ();

  assign bus2.clear       = bus.clear;
  assign bus2.state_valid = bus.state_valid;
  assign bus2.state_in    = bus.state_in;
  assign bus2.legal_mask  = bus.legal_mask;

  fsm_coverage_monitor #(.STATE_W(2), .NUM_STATES(4), .CNT_W(8),
                         .STUCK_LIMIT(16)) dut (
    .clk (clk),
    .rst (rst),
    .mon (bus)
  );

  fsm_coverage_monitor #(.STATE_W(2), .NUM_STATES(4), .CNT_W(2),
                         .STUCK_LIMIT(16)) dut2 (
    .clk (clk),
    .rst (rst),
    .mon (bus2)
  );

  function automatic exp_t mk(logic [3:0] vis, logic av, logic ill,
                              logic [1:0] f, logic [1:0] t,
                              logic [7:0] tc, logic stk, mon_state_t st);
    exp_t e;
    e.vis = vis; e.av = av; e.ill = ill; e.f = f; e.t = t;
    e.tc = tc; e.stk = stk; e.st = st;
    return e;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step(logic r, logic c, logic v, logic [1:0] s, exp_t e);
    exp_t x;
    logic [7:0] tc2;
    sb.push_back(e);
    rst             = r;
    bus.clear       = c;
    bus.state_valid = v;
    bus.state_in    = s;
    @(posedge clk);
    #1;
    x   = sb.pop_front();
    tc2 = (x.tc > 8'd3) ? 8'd3 : x.tc;
    chk("visited",      32'(bus.visited),      32'(x.vis));
    chk("all_visited",  32'(bus.all_visited),  32'(x.av));
    chk("illegal_flag", 32'(bus.illegal_flag), 32'(x.ill));
    chk("illegal_from", 32'(bus.illegal_from), 32'(x.f));
    chk("illegal_to",   32'(bus.illegal_to),   32'(x.t));
    chk("trans_count",  32'(bus.trans_count),  32'(x.tc));
    chk("stuck_flag",   32'(bus.stuck_flag),   32'(x.stk));
    chk("mon_state",    32'(dut.st),           32'(x.st));
    chk("trans_count_w2", 32'(bus2.trans_count), 32'(tc2));
  endtask

  initial begin
    // Ring 0->1->2->3->0 as bit[from*4+to]: bits 1, 6, 11, 12.
    bus.legal_mask = 16'h1842;

    // Reset with a sample present: sample is dropped.
    step(1, 0, 1, 3, mk(4'h0, 0, 0, 0, 0, 0, 0, MON_IDLE));

    // Legal ring walk, then one more change to saturate the 2-bit count.
    step(0, 0, 1, 0, mk(4'h1, 0, 0, 0, 0, 0, 0, MON_TRACK));
    step(0, 0, 1, 1, mk(4'h3, 0, 0, 0, 0, 1, 0, MON_TRACK));
    step(0, 0, 1, 2, mk(4'h7, 0, 0, 0, 0, 2, 0, MON_TRACK));
    step(0, 0, 1, 3, mk(4'hF, 1, 0, 0, 0, 3, 0, MON_TRACK));
    step(0, 0, 1, 0, mk(4'hF, 1, 0, 0, 0, 4, 0, MON_TRACK));
    step(0, 0, 1, 1, mk(4'hF, 1, 0, 0, 0, 5, 0, MON_TRACK));
    step(0, 0, 0, 2, mk(4'hF, 1, 0, 0, 0, 5, 0, MON_TRACK));

    // Clear with a sample in the same cycle, then an illegal jump 0->2.
    step(0, 1, 1, 3, mk(4'h0, 0, 0, 0, 0, 0, 0, MON_IDLE));
    step(0, 0, 1, 0, mk(4'h1, 0, 0, 0, 0, 0, 0, MON_TRACK));
    step(0, 0, 1, 2, mk(4'h5, 0, 1, 0, 2, 0, 0, MON_FAULT));
    step(0, 0, 1, 2, mk(4'h5, 0, 1, 0, 2, 0, 0, MON_FAULT));
    step(0, 0, 1, 3, mk(4'hD, 0, 1, 0, 2, 1, 0, MON_FAULT));
    step(0, 0, 1, 1, mk(4'hF, 1, 1, 0, 2, 1, 0, MON_FAULT));

    // Clear in fault with a sample; next sample sets only its own bit.
    step(0, 1, 1, 2, mk(4'h0, 0, 0, 0, 0, 0, 0, MON_IDLE));
    step(0, 0, 1, 3, mk(4'h8, 0, 0, 0, 0, 0, 0, MON_TRACK));

    // Sixteen consecutive samples of state 1.
    step(0, 1, 0, 0, mk(4'h0, 0, 0, 0, 0, 0, 0, MON_IDLE));
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 1, 1, mk(4'h2, 0, 0, 0, 0, 0, logic'(i == 15), MON_TRACK));
    end

    // Fifteen samples with an invalid gap, then a legal change 1->2.
    step(0, 1, 0, 0, mk(4'h0, 0, 0, 0, 0, 0, 0, MON_IDLE));
    for (int i = 0; i < 15; i++) begin
      step(0, 0, 1, 1, mk(4'h2, 0, 0, 0, 0, 0, 0, MON_TRACK));
      if (i == 7) step(0, 0, 0, 1, mk(4'h2, 0, 0, 0, 0, 0, 0, MON_TRACK));
    end
    step(0, 0, 1, 2, mk(4'h6, 0, 0, 0, 0, 1, 0, MON_TRACK));

    // Reset together with clear while in fault.
    step(0, 1, 0, 0, mk(4'h0, 0, 0, 0, 0, 0, 0, MON_IDLE));
    step(0, 0, 1, 0, mk(4'h1, 0, 0, 0, 0, 0, 0, MON_TRACK));
    step(0, 0, 1, 2, mk(4'h5, 0, 1, 0, 2, 0, 0, MON_FAULT));
    step(1, 1, 1, 3, mk(4'h0, 0, 0, 0, 0, 0, 0, MON_IDLE));
    step(0, 0, 1, 1, mk(4'h2, 0, 0, 0, 0, 0, 0, MON_TRACK));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
